i2s_rx: RTL and testbench

- Oversampling I2S receiver: the inverse of the core's i2s transmitter.
- Deserializes an external sclk/lrclk/sdata stream, such as a codec ADC feeding the audio-in path or a loopback of the core's own I2S output, into parallel left/right samples in the system clock domain.
- All I2S inputs are treated as asynchronous and are sampled by clk.
- A one-cycle strobe marks each complete stereo pair.

---
 rtl/i2s_rx.sv | 115 +++++++++++
 tb/tb_i2s_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// Oversampling I2S receiver: deserializes sclk/lrclk/sdata into
// parallel left/right samples in the clk domain.
module i2s_rx #(
    parameter int AUDIO_DW   = 16,
    parameter bit LEFT_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                sample_valid,
    output logic                short_word,
    output logic                locked
);

    localparam int LW = (AUDIO_DW > 1) ? $clog2(AUDIO_DW) : 1;
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] FULL = CW'(AUDIO_DW);
    localparam logic [LW-1:0] TOP  = LW'(AUDIO_DW - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t              state;
    logic                sclk_s1, sclk_s2, sclk_s3;
    logic                lr_s1, lr_s2;
    logic                sd_s1, sd_s2;
    logic                prev_lr;
    logic                got_left;
    logic [AUDIO_DW-1:0] sr;
    logic [CW-1:0]       cnt;

    logic                bit_edge;
    logic [AUDIO_DW-1:0] sr_nxt;
    logic [CW-1:0]       cnt_nxt;
    logic                is_short;

    assign bit_edge = sclk_s2 & ~sclk_s3;

    // Word value with the current bit stored; extra bits past FULL are dropped.
    always_comb begin
        sr_nxt  = sr;
        cnt_nxt = cnt;
        if (cnt < FULL) begin
            sr_nxt[TOP - cnt[LW-1:0]] = sd_s2;
            cnt_nxt = cnt + CW'(1);
        end
        is_short = (cnt_nxt < FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= INIT;
            sclk_s1      <= 1'b0;
            sclk_s2      <= 1'b0;
            sclk_s3      <= 1'b0;
            lr_s1        <= 1'b0;
            lr_s2        <= 1'b0;
            sd_s1        <= 1'b0;
            sd_s2        <= 1'b0;
            prev_lr      <= 1'b0;
            got_left     <= 1'b0;
            sr           <= '0;
            cnt          <= '0;
            left_chan    <= '0;
            right_chan   <= '0;
            sample_valid <= 1'b0;
            short_word   <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sclk_s1      <= sclk;
            sclk_s2      <= sclk_s1;
            sclk_s3      <= sclk_s2;
            lr_s1        <= lrclk;
            lr_s2        <= lr_s1;
            sd_s1        <= sdata;
            sd_s2        <= sd_s1;
            sample_valid <= 1'b0;
            short_word   <= 1'b0;
            if (bit_edge) begin
                if (lr_s2 != prev_lr) begin
                    // The bit on a word-select change is the old word's LSB slot.
                    prev_lr <= lr_s2;
                    sr      <= '0;
                    cnt     <= '0;
                    if (state == INIT) begin
                        state <= RUN;
                    end else begin
                        short_word <= is_short;
                        if (prev_lr == LEFT_LEVEL) begin
                            left_chan <= sr_nxt;
                            got_left  <= 1'b1;
                        end else begin
                            right_chan <= sr_nxt;
                            if (got_left) begin
                                sample_valid <= 1'b1;
                                locked       <= 1'b1;
                                got_left     <= 1'b0;
                            end
                        end
                    end
                end else begin
                    sr  <= sr_nxt;
                    cnt <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: I2S frames with one-bit delay, sclk = clk/12.
`timescale 1ns/1ps
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk = 1'b0;
    logic        lrclk = 1'b0;
    logic        sdata = 1'b0;
    logic [15:0] left_chan, right_chan;
    logic        sample_valid, short_word, locked;
    logic [15:0] l1, r1;
    logic        sv1, sw1, lk1;

    int checks = 0;
    int passed = 0;
    int sv_cnt = 0;
    int sw_cnt = 0;
    logic pend = 1'b0;

    always #5 clk = ~clk;

    i2s_rx #(.AUDIO_DW(16), .LEFT_LEVEL(1'b0)) u_dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk),
        .lrclk(lrclk), .sdata(sdata),
        .left_chan(left_chan), .right_chan(right_chan),
        .sample_valid(sample_valid), .short_word(short_word),
        .locked(locked)
    );

    i2s_rx #(.AUDIO_DW(16), .LEFT_LEVEL(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk),
        .lrclk(lrclk), .sdata(sdata),
        .left_chan(l1), .right_chan(r1),
        .sample_valid(sv1), .short_word(sw1),
        .locked(lk1)
    );

    always @(posedge clk) begin
        if (sample_valid) sv_cnt <= sv_cnt + 1;
        if (short_word) sw_cnt <= sw_cnt + 1;
    end

    // One sclk period; lat = posedge index (1..6) after the rise where sample_valid shows.
    task automatic slot(input logic lv, input logic b, output int lat);
        lrclk = lv;
        sdata = b;
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        sclk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (sample_valid && lat == 0) lat = k;
        end
        @(negedge clk);
    endtask

    task automatic send_part(input logic lv, input logic [31:0] w,
                             input int n, input int first, input int last);
        int lat;
        for (int i = first; i < last; i++) begin
            slot(lv, pend, lat);
            pend = w[n-1-i];
        end
    endtask

    task automatic send_word(input logic lv, input logic [31:0] w, input int n);
        send_part(lv, w, n, 0, n);
    endtask

    task automatic flush(input logic lv, output int lat);
        slot(lv, pend, lat);
        pend = 1'b0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        sclk = 1'b0;
        lrclk = 1'b0;
        sdata = 1'b0;
        pend = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (left_chan !== 16'h0 || right_chan !== 16'h0)
            $display("FAIL reset_chan: got %h/%h want 0000/0000",
                     left_chan, right_chan);
        else passed++;
        checks++;
        if ({sample_valid, short_word, locked} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000",
                     {sample_valid, short_word, locked});
        else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned;
        int s0, w0, lat;
        do_reset();
        s0 = sv_cnt;
        w0 = sw_cnt;
        send_word(1'b0, 32'h0F0F, 16);
        send_word(1'b1, 32'hF0F0, 16);
        send_word(1'b0, 32'hA55A, 16);
        send_word(1'b1, 32'h1234, 16);
        checks++;
        if (sv_cnt - s0 !== 0)
            $display("FAIL aligned_early_valid: got %0d want 0", sv_cnt - s0);
        else passed++;
        flush(1'b0, lat);
        checks++;
        if (lat < 3 || lat > 4)
            $display("FAIL aligned_latency: got %0d want 3..4", lat);
        else passed++;
        checks++;
        if (sv_cnt - s0 !== 1)
            $display("FAIL aligned_valid_count: got %0d want 1", sv_cnt - s0);
        else passed++;
        checks++;
        if (left_chan !== 16'hA55A)
            $display("FAIL aligned_left: got %h want a55a", left_chan);
        else passed++;
        checks++;
        if (right_chan !== 16'h1234)
            $display("FAIL aligned_right: got %h want 1234", right_chan);
        else passed++;
        checks++;
        if (locked !== 1'b1)
            $display("FAIL aligned_locked: got %b want 1", locked);
        else passed++;
        checks++;
        if (sw_cnt - w0 !== 0)
            $display("FAIL aligned_short: got %0d want 0", sw_cnt - w0);
        else passed++;
    endtask

    task automatic test_left_level;
        checks++;
        if (l1 !== 16'h1234)
            $display("FAIL ll1_left: got %h want 1234", l1);
        else passed++;
        checks++;
        if (r1 !== 16'hA55A)
            $display("FAIL ll1_right: got %h want a55a", r1);
        else passed++;
    endtask

    task automatic test_mid_word;
        int s0, w0, lat;
        reset_n = 1'b0;
        pend = 1'b0;
        for (int i = 0; i < 6; i++) slot(1'b1, 1'b1, lat);
        reset_n = 1'b1;
        s0 = sv_cnt;
        w0 = sw_cnt;
        for (int i = 0; i < 10; i++) slot(1'b1, 1'b1, lat);
        pend = 1'b0;
        send_word(1'b0, 32'h0001, 16);
        send_word(1'b1, 32'h8000, 16);
        checks++;
        if (sv_cnt - s0 !== 0)
            $display("FAIL mid_partial_valid: got %0d want 0", sv_cnt - s0);
        else passed++;
        flush(1'b0, lat);
        checks++;
        if (sv_cnt - s0 !== 1)
            $display("FAIL mid_valid_count: got %0d want 1", sv_cnt - s0);
        else passed++;
        checks++;
        if (left_chan !== 16'h0001 || right_chan !== 16'h8000)
            $display("FAIL mid_pair: got %h/%h want 0001/8000",
                     left_chan, right_chan);
        else passed++;
        checks++;
        if (sw_cnt - w0 !== 1)
            $display("FAIL mid_short: got %0d want 1", sw_cnt - w0);
        else passed++;
    endtask

    task automatic test_long;
        int s0, w0, lat;
        do_reset();
        s0 = sv_cnt;
        w0 = sw_cnt;
        send_word(1'b0, 32'h123456, 24);
        send_word(1'b1, 32'h654321, 24);
        send_word(1'b0, 32'hFFEE11, 24);
        send_word(1'b1, 32'h00FF80, 24);
        flush(1'b0, lat);
        checks++;
        if (left_chan !== 16'hFFEE || right_chan !== 16'h00FF)
            $display("FAIL long_pair: got %h/%h want ffee/00ff",
                     left_chan, right_chan);
        else passed++;
        checks++;
        if (sw_cnt - w0 !== 0)
            $display("FAIL long_short: got %0d want 0", sw_cnt - w0);
        else passed++;
        checks++;
        if (sv_cnt - s0 !== 1)
            $display("FAIL long_valid: got %0d want 1", sv_cnt - s0);
        else passed++;
    endtask

    task automatic test_short;
        int s0, w0, lat;
        do_reset();
        s0 = sv_cnt;
        w0 = sw_cnt;
        send_word(1'b0, 32'hAA, 8);
        send_word(1'b1, 32'h55, 8);
        send_word(1'b0, 32'hC3, 8);
        send_word(1'b1, 32'h3C, 8);
        flush(1'b0, lat);
        checks++;
        if (left_chan !== 16'hC300 || right_chan !== 16'h3C00)
            $display("FAIL short_pair: got %h/%h want c300/3c00",
                     left_chan, right_chan);
        else passed++;
        checks++;
        if (sw_cnt - w0 !== 3)
            $display("FAIL short_pulses: got %0d want 3", sw_cnt - w0);
        else passed++;
        checks++;
        if (sv_cnt - s0 !== 1)
            $display("FAIL short_valid: got %0d want 1", sv_cnt - s0);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int s0, lat;
        send_part(1'b0, 32'h1111, 16, 0, 7);
        reset_n = 1'b0;
        #2;
        checks++;
        if (left_chan !== 16'h0 || right_chan !== 16'h0 || locked !== 1'b0)
            $display("FAIL rmid_clear: got %h/%h/%b want 0000/0000/0",
                     left_chan, right_chan, locked);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        s0 = sv_cnt;
        send_part(1'b0, 32'h1111, 16, 7, 16);
        send_word(1'b1, 32'h2222, 16);
        send_word(1'b0, 32'h5A5A, 16);
        checks++;
        if (sv_cnt - s0 !== 0 || locked !== 1'b0)
            $display("FAIL rmid_early: got valid %0d locked %b want 0/0",
                     sv_cnt - s0, locked);
        else passed++;
        send_word(1'b1, 32'hC0DE, 16);
        flush(1'b0, lat);
        checks++;
        if (sv_cnt - s0 !== 1 || locked !== 1'b1)
            $display("FAIL rmid_valid: got valid %0d locked %b want 1/1",
                     sv_cnt - s0, locked);
        else passed++;
        checks++;
        if (left_chan !== 16'h5A5A || right_chan !== 16'hC0DE)
            $display("FAIL rmid_pair: got %h/%h want 5a5a/c0de",
                     left_chan, right_chan);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_left_level();
        test_mid_word();
        test_long();
        test_short();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
